// File: rtl/seg_scan_reader.sv
// seg_scan_reader
// Read-side scanner for an 8-digit, time-multiplexed, active-low 7-segment
// display. It walks digit locations 0..7 over a synchronous read port with
// 1-cycle latency, decodes each returned hex nibble and lights one anode per
// refresh slot. Each slot is FETCH (1 cycle), WAIT (1 cycle), then SHOW
// (REFRESH_DIV cycles), so the anodes are dark for two cycles between
// digits and no stale segment pattern ever appears under a new anode.
//
// Optional build macro: SEG_SCAN_DP_EN
//   When defined, adds input dp_mask[7:0] and an active-low decimal point
//   output dp that is registered together with the segments.
//
// Parameter constraints: REFRESH_DIV >= 2 and 2**CNT_W >= REFRESH_DIV.

module seg_scan_reader #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       rd_en,
  output logic [2:0] rd_addr,
  input  logic [3:0] rd_data,
  input  logic [7:0] blank_mask,
`ifdef SEG_SCAN_DP_EN
  input  logic [7:0] dp_mask,
  output logic       dp,
`endif
  output logic [6:0] segments,
  output logic [7:0] anode,
  output logic       frame_done
);

  // Scan states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] SHOW  = 2'd3;

  // Dark patterns for the active-low pins
  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Last SHOW cycle of a slot
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  // One-hot active-low anode for a digit index
  function automatic logic [7:0] idx_to_anode(input logic [2:0] i);
    logic [7:0] one_hot;
    one_hot = 8'h01 << i;
    return ~one_hot;
  endfunction

  logic [1:0]       state;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       state_nxt;
  logic [2:0]       idx_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rd_en_nxt;
  logic [2:0]       rd_addr_nxt;
  logic [6:0]       seg_nxt;
  logic [7:0]       anode_nxt;
  logic             frame_nxt;
`ifdef SEG_SCAN_DP_EN
  logic             dp_nxt;
`endif

  // Next-state and next-output computation for the scan sequencer
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = rd_addr;
    seg_nxt     = segments;
    anode_nxt   = anode;
    frame_nxt   = 1'b0;
`ifdef SEG_SCAN_DP_EN
    dp_nxt      = dp;
`endif
    if (!enable) begin
      // Disable wins in every state: go dark and forget the scan position
      state_nxt   = IDLE;
      idx_nxt     = 3'd0;
      cnt_nxt     = '0;
      rd_addr_nxt = 3'd0;
      seg_nxt     = SEG_OFF;
      anode_nxt   = ANODE_OFF;
`ifdef SEG_SCAN_DP_EN
      dp_nxt      = 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Start a fresh frame at digit 0; the read strobe rises with FETCH
          state_nxt   = FETCH;
          idx_nxt     = 3'd0;
          cnt_nxt     = '0;
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = 3'd0;
          seg_nxt     = SEG_OFF;
          anode_nxt   = ANODE_OFF;
`ifdef SEG_SCAN_DP_EN
          dp_nxt      = 1'b1;
`endif
        end
        FETCH: begin
          // Read is in flight; keep the display dark
          state_nxt = WAIT;
          seg_nxt   = SEG_OFF;
          anode_nxt = ANODE_OFF;
`ifdef SEG_SCAN_DP_EN
          dp_nxt    = 1'b1;
`endif
        end
        WAIT: begin
          // rd_data is valid now: decode it and light the digit next edge
          state_nxt = SHOW;
          cnt_nxt   = '0;
          seg_nxt   = hex_to_seg(rd_data);
          frame_nxt = (idx == 3'd7);
          if (blank_mask[idx]) begin
            anode_nxt = ANODE_OFF;
`ifdef SEG_SCAN_DP_EN
            dp_nxt    = 1'b1;
`endif
          end else begin
            anode_nxt = idx_to_anode(idx);
`ifdef SEG_SCAN_DP_EN
            dp_nxt    = ~dp_mask[idx];
`endif
          end
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            // Slot over: blank the pins and fetch the next digit (7 wraps to 0)
            state_nxt   = FETCH;
            cnt_nxt     = '0;
            idx_nxt     = idx + 3'd1;
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = idx + 3'd1;
            seg_nxt     = SEG_OFF;
            anode_nxt   = ANODE_OFF;
`ifdef SEG_SCAN_DP_EN
            dp_nxt      = 1'b1;
`endif
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          // Unreachable encoding: recover to a dark idle display
          state_nxt   = IDLE;
          idx_nxt     = 3'd0;
          cnt_nxt     = '0;
          rd_addr_nxt = 3'd0;
          seg_nxt     = SEG_OFF;
          anode_nxt   = ANODE_OFF;
`ifdef SEG_SCAN_DP_EN
          dp_nxt      = 1'b1;
`endif
        end
      endcase
    end
  end

  // State and registered outputs; reset forces the dark display at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      cnt        <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= 3'd0;
      segments   <= SEG_OFF;
      anode      <= ANODE_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      rd_en      <= rd_en_nxt;
      rd_addr    <= rd_addr_nxt;
      segments   <= seg_nxt;
      anode      <= anode_nxt;
      frame_done <= frame_nxt;
    end
  end

`ifdef SEG_SCAN_DP_EN
  // Decimal point register, updated alongside the segments
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp <= 1'b1;
    end else begin
      dp <= dp_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_reader.sv
// Self-checking bench for seg_scan_reader (REFRESH_DIV = 4).
// A behavioural model derives every expected output from the position of the
// current cycle inside the frame (slot = digit, offset inside the slot), plus
// the memory/blank values seen when each digit was read.
// Optional build macro: SEG_SCAN_DP_EN (also checks the dp output).

module tb_seg_scan_reader;

  localparam int RD    = 4;
  localparam int SLOT  = RD + 2;
  localparam int FRAME = 8 * SLOT;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic       clk;
  logic       reset;
  logic       enable;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic [3:0] rd_data;
  logic [7:0] blank_mask;
  logic [6:0] segments;
  logic [7:0] anode;
  logic       frame_done;
`ifdef SEG_SCAN_DP_EN
  logic [7:0] dp_mask;
  logic       dp;
`endif

  seg_scan_reader #(.REFRESH_DIV(RD), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .blank_mask (blank_mask),
`ifdef SEG_SCAN_DP_EN
    .dp_mask    (dp_mask),
    .dp         (dp),
`endif
    .segments   (segments),
    .anode      (anode),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digit store model: 1-cycle synchronous read
  logic [3:0] mem [8];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int checks   = 0;
  int failures = 0;

  // Model state: cycle index since the scan (re)started, captured slot data
  int         t = 0;
  logic [3:0] cap_digit = 4'h0;
  logic       cap_blank = 1'b0;
  logic       cap_dp    = 1'b0;
  int         fd_count  = 0;
  int         lit_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Display must be fully dark with no read activity
  task automatic chk_dark(input string tag);
    chk({tag, "_anode"}, 32'(anode), 32'hFF);
    chk({tag, "_seg"}, 32'(segments), 32'h7F);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'h0);
    chk({tag, "_frame"}, 32'(frame_done), 32'h0);
`ifdef SEG_SCAN_DP_EN
    chk({tag, "_dp"}, 32'(dp), 32'h1);
`endif
  endtask

  // Advance one clock and compare every output with the frame-position model
  task automatic step();
    int p, slot, off;
    logic [7:0] exp_anode;
    @(posedge clk);
    #1;
    p    = t % FRAME;
    slot = p / SLOT;
    off  = p % SLOT;
    if (off == 1) cap_digit = mem[slot];
    if (off == 2) begin
      cap_blank = blank_mask[slot];
`ifdef SEG_SCAN_DP_EN
      cap_dp = dp_mask[slot];
`else
      cap_dp = 1'b0;
`endif
    end
    chk("rd_en", 32'(rd_en), 32'(off == 0));
    if (off == 0) chk("rd_addr", 32'(rd_addr), 32'(slot));
    chk("frame_done", 32'(frame_done), 32'(slot == 7 && off == 2));
    if (frame_done === 1'b1) fd_count++;
    if (off < 2) begin
      chk("gap_anode", 32'(anode), 32'hFF);
`ifdef SEG_SCAN_DP_EN
      chk("gap_dp", 32'(dp), 32'h1);
`endif
    end else begin
      exp_anode = 8'h01 << slot;
      exp_anode = cap_blank ? 8'hFF : ~exp_anode;
      chk("show_anode", 32'(anode), 32'(exp_anode));
      chk("show_seg", 32'(segments), 32'(SEG_TAB[cap_digit]));
      if (anode !== 8'hFF) lit_count++;
`ifdef SEG_SCAN_DP_EN
      chk("show_dp", 32'(dp), 32'(cap_blank ? 1'b1 : ~cap_dp));
`endif
    end
    t++;
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    enable     = 1'b1;
    blank_mask = 8'h00;
`ifdef SEG_SCAN_DP_EN
    dp_mask    = 8'h04;
`endif
    for (int i = 0; i < 8; i++) mem[i] = 4'(i);
    mem[0] = 4'h3;

    // Reset holds the display dark even with enable high
    repeat (3) @(posedge clk);
    #1;
    chk_dark("reset");
    chk("reset_rd_addr", 32'(rd_addr), 32'h0);

    // Release: first read of digit 0, digit 0 shows '3' two cycles later
    reset = 1'b0;
    t = 0;
    step();
    chk("first_rd_en", 32'(rd_en), 32'h1);
    chk("first_rd_addr", 32'(rd_addr), 32'h0);
    step();
    step();
    chk("first_seg", 32'(segments), 32'h30);
    chk("first_anode", 32'(anode), 32'hFE);
    mem[0] = 4'h0;

    // Two full frames: digits 0..7, one frame_done per 48 cycles
    fd_count = 0;
    while (t < 2 * FRAME) step();
    chk("frame_done_count", 32'(fd_count), 32'd2);

    // Blanking and wrap: digits 0 and 7 dark, the rest show F
    blank_mask = 8'h81;
    for (int i = 0; i < 8; i++) mem[i] = 4'hF;
    lit_count = 0;
    repeat (FRAME) step();
    chk("blank_lit_cycles", 32'(lit_count), 32'd24);
    repeat (FRAME) step();

    // Random digit writes and blank changes at arbitrary times
    for (int k = 0; k < 3 * FRAME; k++) begin
      step();
      if ($urandom_range(3) == 0) mem[$urandom_range(7)] = 4'($urandom);
      if ($urandom_range(7) == 0) blank_mask = 8'($urandom);
    end

    // Enable drop in the middle of digit 3's SHOW
    blank_mask = 8'h00;
    n = ((21 - (t % FRAME)) + FRAME) % FRAME + 1;
    repeat (n) step();
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk_dark("en_drop");
    end
    enable = 1'b1;
    t = 0;
    repeat (2 * SLOT) step();

    // Async reset while in FETCH of digit 2, between edges
    n = ((12 - (t % FRAME)) + FRAME) % FRAME + 1;
    repeat (n) step();
    #2;
    reset = 1'b1;
    #1;
    chk_dark("async_rst");
    chk("async_rst_rd_addr", 32'(rd_addr), 32'h0);
    @(posedge clk);
    #1;
    chk_dark("rst_held");
    reset = 1'b0;
    t = 0;
    repeat (FRAME + SLOT) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
